// File: rtl/pga_spi_responder_if.sv
// Gain-link bundle between the PGA writer and the responder.
// Serial select/data in, latched code and status back out.
interface pga_spi_responder_if #(
  parameter int WIDTH = 8
);
  logic             cs_n;
  logic             mosi;
  logic [WIDTH-1:0] code_o;
  logic             valid_o;
  logic             err_o;
  logic             busy_o;
  logic [7:0]       frames_o;

  modport master (
    output cs_n, mosi,
    input  code_o, valid_o, err_o, busy_o, frames_o
  );

  modport slave (
    input  cs_n, mosi,
    output code_o, valid_o, err_o, busy_o, frames_o
  );
endinterface

// File: rtl/pga_spi_responder.sv
// Receive side of the PGA gain link: assembles MSB-first
// frames, latches good ones as the gain code, flags framing errors.
module pga_spi_responder #(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
  input  logic sck,
  input  logic rst_n,
  pga_spi_responder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    SHIFT,
    OVERRUN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] code_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             valid_q;
  logic             err_q;
  logic             busy_q;
  logic [7:0]       frames_q;

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      shift_q   <= '0;
      code_q    <= RESET_CODE;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      frames_q  <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        // Wait out any frame that reset cut in half.
        SYNC: begin
          if (bus.cs_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (!bus.cs_n) begin
            shift_q   <= {shift_q[WIDTH-2:0], bus.mosi};
            bit_cnt_q <= ONE;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.cs_n) begin
            if (bit_cnt_q < FULL) begin
              shift_q   <= {shift_q[WIDTH-2:0], bus.mosi};
              bit_cnt_q <= bit_cnt_q + ONE;
            end else begin
              state_q <= OVERRUN;
            end
          end else begin
            if (bit_cnt_q == FULL) begin
              code_q   <= shift_q;
              valid_q  <= 1'b1;
              frames_q <= frames_q + 8'd1;
            end else begin
              err_q <= 1'b1;
            end
            bit_cnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
        OVERRUN: begin
          if (bus.cs_n) begin
            err_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.code_o   = code_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;
  assign bus.busy_o   = busy_q;
  assign bus.frames_o = frames_q;

endmodule

// File: tb/tb_pga_spi_responder.sv
// Bench for pga_spi_responder: table vectors, reset and wrap
// sequences, then random frames against a frame-level model.
module tb_pga_spi_responder;

  logic sck;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_valid;
  logic [7:0] m_code;
  int   m_frames;

  pga_spi_responder_if #(.WIDTH(8)) bus ();

  pga_spi_responder #(
    .WIDTH(8),
    .RESET_CODE(8'h00)
  ) dut (
    .sck(sck),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          gap;
    logic        ev;
    logic        ee;
    logic [7:0]  ec;
    logic [7:0]  ef;
  } vec_t;

  vec_t tbl[7];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is aligned on a negedge; bits go out MSB first.
  task automatic send_frame(logic [15:0] bits, int n, int gap,
                            logic ev, logic ee,
                            logic [7:0] ec, logic [7:0] ef,
                            string tag);
    logic bok;
    bok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.cs_n = 1'b0;
      bus.mosi = bits[n-1-i];
      @(negedge sck);
      if (bus.busy_o !== 1'b1) bok = 1'b0;
    end
    bus.cs_n = 1'b1;
    bus.mosi = 1'($urandom);
    @(negedge sck);
    check({tag, " valid"}, 32'(bus.valid_o), 32'(ev));
    check({tag, " err"}, 32'(bus.err_o), 32'(ee));
    check({tag, " code"}, 32'(bus.code_o), 32'(ec));
    check({tag, " frames"}, 32'(bus.frames_o), 32'(ef));
    check({tag, " busy_idle"}, 32'(bus.busy_o), 32'd0);
    if (n > 0) check({tag, " busy_frame"}, 32'(bok), 32'd1);
    if (bus.valid_o === 1'b1) n_valid++;
    for (int g = 0; g < gap; g++) begin
      bus.mosi = 1'($urandom);
      @(negedge sck);
      check({tag, " pulse_end"},
            32'({bus.valid_o, bus.err_o}), 32'd0);
    end
  endtask

  // Frame-level model: exactly 8 bits is a good frame,
  // zero bits is nothing, anything else is a framing error.
  task automatic send_model(logic [15:0] bits, int n, int gap,
                            string tag);
    logic ev;
    logic ee;
    ev = (n == 8);
    ee = (n != 8) && (n != 0);
    if (ev) begin
      m_code   = bits[7:0];
      m_frames = (m_frames + 1) % 256;
    end
    send_frame(bits, n, gap, ev, ee, m_code, 8'(m_frames), tag);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);
    m_code   = 8'h00;
    m_frames = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_valid  = 0;
    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;

    tbl[0] = '{16'h008F,  8, 2, 1'b1, 1'b0, 8'h8F, 8'd1};
    tbl[1] = '{16'h0016,  5, 1, 1'b0, 1'b1, 8'h8F, 8'd1};
    tbl[2] = '{16'h0157, 10, 1, 1'b0, 1'b1, 8'h8F, 8'd1};
    tbl[3] = '{16'h00A5,  8, 0, 1'b1, 1'b0, 8'hA5, 8'd2};
    tbl[4] = '{16'h003C,  8, 1, 1'b1, 1'b0, 8'h3C, 8'd3};
    tbl[5] = '{16'h0001,  1, 1, 1'b0, 1'b1, 8'h3C, 8'd3};
    tbl[6] = '{16'h0000,  0, 1, 1'b0, 1'b0, 8'h3C, 8'd3};

    #1;
    check("rst code", 32'(bus.code_o), 32'h00);
    check("rst valid", 32'(bus.valid_o), 32'd0);
    check("rst err", 32'(bus.err_o), 32'd0);
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst frames", 32'(bus.frames_o), 32'd0);

    @(negedge sck);
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);
    @(negedge sck);

    for (int k = 0; k < 7; k++)
      send_frame(tbl[k].bits, tbl[k].n, tbl[k].gap,
                 tbl[k].ev, tbl[k].ee, tbl[k].ec, tbl[k].ef,
                 $sformatf("vec%0d", k));

    // Reset cuts a frame after 4 bits; select stays low after.
    for (int i = 0; i < 4; i++) begin
      bus.cs_n = 1'b0;
      bus.mosi = 1'(i);
      @(negedge sck);
    end
    rst_n = 1'b0;
    #1;
    check("midrst code", 32'(bus.code_o), 32'h00);
    check("midrst frames", 32'(bus.frames_o), 32'd0);
    check("midrst busy", 32'(bus.busy_o), 32'd0);
    @(negedge sck);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cs_n = 1'b0;
      bus.mosi = 1'($urandom);
      @(negedge sck);
      check("sync busy", 32'(bus.busy_o), 32'd0);
    end
    bus.cs_n = 1'b1;
    @(negedge sck);
    check("sync pulses", 32'({bus.valid_o, bus.err_o}), 32'd0);
    check("sync code", 32'(bus.code_o), 32'h00);
    m_code   = 8'h00;
    m_frames = 0;
    send_model(16'h0012, 8, 1, "post_rst");

    // 256 good frames wrap the counter back to zero.
    do_reset();
    n_valid = 0;
    for (int k = 0; k < 256; k++)
      send_model(16'h0001, 8, k % 2, "wrap");
    check("wrap frames", 32'(bus.frames_o), 32'd0);
    check("wrap pulses", 32'(n_valid), 32'd256);

    for (int k = 0; k < 300; k++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 11) : 8;
      send_model(16'($urandom), n, $urandom_range(0, 2), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pga_spi_responder.md
# pga_spi_responder

Receive-side model and checker for the PGA gain-setting serial link. The block samples `cs_n`/`mosi` on the shared `sck`, assembles MSB-first frames and latches each complete frame as the active gain code. It flags framing errors. It sits opposite the PGA write interface: in simulation it is the PGA stand-in, and in hardware loopback it is the readback/monitor of the gain bus.

## Interface
- `WIDTH`, 8: bits per frame; MSB shifted first.
- `RESET_CODE`, 8'h00: value of `code_o` after reset.
- `sck` input 1: single clock; all logic on the rising edge. It is the same clock that drives the link.
- `rst_n` input 1: asynchronous active-low reset. Release is synchronised externally.
- `cs_n` input 1: frame select, active low.
- `mosi` input 1: serial data. Valid on rising `sck` while `cs_n`=0.
- `code_o` output WIDTH: last correctly framed code.
- `valid_o` output 1: one-cycle pulse when `code_o` updates.
- `err_o` output 1: one-cycle pulse on a framing error.
- `busy_o` output 1: high while a frame is in progress (state SHIFT or OVERRUN).
- `frames_o` output 8: count of accepted frames; wraps 255→0.

## Operation
- Registers:
  - `shift`, WIDTH bits.
  - `bit_cnt`, $clog2(WIDTH+1) bits.
  - state ∈ {SYNC, IDLE, SHIFT, OVERRUN}.
- Async reset values:
  - state=SYNC, `shift`=0, `bit_cnt`=0.
  - `code_o`=RESET_CODE, `valid_o`=0, `err_o`=0, `busy_o`=0, `frames_o`=0.
- Every edge clears `valid_o` and `err_o` unless the edge sets them.
- Per rising edge, by state:
  - SYNC: ignore `mosi`. When `cs_n`=1, go to IDLE. This discards any frame cut by reset; it produces no valid and no error.
  - IDLE, `cs_n`=0: shift in `mosi` as the first bit (`shift`<={shift[WIDTH-2:0],mosi}), set `bit_cnt`=1, go to SHIFT. IDLE with `cs_n`=1: stay.
  - SHIFT, `cs_n`=0:
    - If `bit_cnt`<WIDTH: shift in `mosi` and increment `bit_cnt`.
    - If `bit_cnt`=WIDTH: the extra bit is an overrun. Go to OVERRUN; `shift` is unchanged.
  - SHIFT, `cs_n`=1:
    - If `bit_cnt`=WIDTH: `code_o`<=`shift`, `valid_o`<=1, `frames_o`<=`frames_o`+1 (mod 256).
    - Otherwise (short frame): `err_o`<=1 and `code_o` holds.
    - In both cases, clear `bit_cnt` and go to IDLE.
  - OVERRUN, `cs_n`=0: ignore `mosi` and stay.
  - OVERRUN, `cs_n`=1: `err_o`<=1, `code_o` holds, go to IDLE.
- `busy_o` is registered: it is 1 in the cycle after entering SHIFT or OVERRUN, and 0 in the cycle after entering IDLE or SYNC.
- Back-to-back frames:
  - One edge with `cs_n`=1 between frames is sufficient. That edge closes the old frame.
  - The next edge with `cs_n`=0 is bit 0 of the new frame.
  - No dead cycle is required.

## Timing
- A frame is WIDTH consecutive rising edges with `cs_n`=0, followed by one edge with `cs_n`=1.
- Latency:
  - `code_o`, `valid_o` and `frames_o` change on the first edge that samples `cs_n`=1 after the final bit.
  - They are visible for the cycle after that edge.
  - `valid_o` is high for exactly one cycle.
- `err_o` has the same timing as `valid_o`: it is set on the closing edge and high for one cycle.
- Zero-length select: `cs_n` low for 0 edges never leaves IDLE, so it produces no pulse.
- One-bit frame with WIDTH=8 produces `err_o`.
- `valid_o` and `err_o` are never high in the same cycle.
- Reset asserted mid-frame:
  - All outputs go to reset values immediately (async).
  - After release, the block stays in SYNC until `cs_n`=1 is sampled.
- `mosi` is don't-care whenever `cs_n`=1.

## Test plan
- Reset release, then frame 0x8F MSB-first (8 edges `cs_n`=0), then `cs_n`=1 → `code_o`=0x8F and `valid_o` high for one cycle on the cycle after the closing edge. `frames_o`=1, `err_o` never high.
- Frame of 5 bits (10110), then `cs_n`=1 → `err_o` pulses once. `code_o` keeps its previous value 0x8F and `frames_o` is unchanged.
- Frame of 10 bits starting 0x55 → `busy_o` stays high through all 10 bits. On close, `err_o` pulses, `code_o` is unchanged and `valid_o` stays 0.
- Frames 0xA5 then 0x3C separated by exactly one `cs_n`=1 edge → two `valid_o` pulses, with `code_o`=0xA5 then 0x3C and `frames_o` incremented by 2.
- `rst_n` pulsed low after 4 bits of a frame while `cs_n` stays low for 4 more bits, then high; then full frame 0x12:
  - During reset: `code_o`=RESET_CODE.
  - The cut frame gives no `valid_o` and no `err_o`.
  - Then `code_o`=0x12 and `frames_o`=1.
- 256 good frames of 0x01 → `frames_o` wraps to 0x00 after the 256th frame, with 256 `valid_o` pulses counted.
